// File: rtl/interval_timer_ctrl_pkg.sv
// Shared definitions for the interval timer controller: state encoding,
// default widths and a width helper.
package interval_timer_ctrl_pkg;

    localparam int DEF_W  = 8;
    localparam int DEF_RW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to represent values 0..value-1.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/interval_timer_ctrl_if.sv
// Control/status bundle between a host and the interval timer controller.
interface interval_timer_ctrl_if
    import interval_timer_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int RW = DEF_RW
);
    logic          start;
    logic          stop;
    logic          tick;
    logic [W-1:0]  period;
    logic [RW-1:0] reps;
    logic [W-1:0]  Q;
    logic          busy;
    logic          rollover;
    logic          done;
    logic          err;

    modport master (
        output start, stop, tick, period, reps,
        input  Q, busy, rollover, done, err
    );

    modport slave (
        input  start, stop, tick, period, reps,
        output Q, busy, rollover, done, err
    );
endinterface

// File: rtl/interval_timer_ctrl_mod_counter_var.sv
// Modulo counter with a runtime modulus; wrap flags the enabled P-1 -> 0 step.
module mod_counter_var
    import interval_timer_ctrl_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         clr,
    input  logic         enable,
    input  logic [W-1:0] modulus,
    output logic [W-1:0] Q,
    output logic         wrap
);

    assign wrap = enable && (Q == modulus - 1'b1);

    // Clear has priority so a stop on a terminal-count tick still zeroes Q.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            Q <= '0;
        end else if (clr) begin
            Q <= '0;
        end else if (enable) begin
            Q <= wrap ? '0 : Q + 1'b1;
        end
    end

endmodule

// File: rtl/interval_timer_ctrl.sv
// Run sequencer around a modulo counter: start/stop, repetition count,
// registered rollover/done/err pulses.
module interval_timer_ctrl
    import interval_timer_ctrl_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int RW = DEF_RW
) (
    input  logic                 clk,
    input  logic                 aclr,
    interval_timer_ctrl_if.slave bus
);

    state_t        state_q, state_d;
    logic [W-1:0]  period_q;
    logic [RW-1:0] rep_q;
    logic [W-1:0]  count;
    logic          wrap;
    logic          cnt_en, cnt_clr;
    logic          load, rep_dec, roll_d, err_d;
    logic          busy, rollover, done, err;

    // Stop masks the tick, so a coincident wrap is never seen.
    assign cnt_en  = (state_q == ST_RUN) && bus.tick && !bus.stop;
    assign cnt_clr = (state_q != ST_RUN) || bus.stop;

    mod_counter_var #(.W(W)) u_cnt (
        .clk     (clk),
        .aclr    (aclr),
        .clr     (cnt_clr),
        .enable  (cnt_en),
        .modulus (period_q),
        .Q       (count),
        .wrap    (wrap)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        rep_dec = 1'b0;
        roll_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.period != '0) begin
                        load    = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                end else if (wrap) begin
                    roll_d = 1'b1;
                    // reps==0 means free-running; it is never decremented.
                    if (rep_q == RW'(1)) begin
                        state_d = ST_DONE;
                    end else if (rep_q > RW'(1)) begin
                        rep_dec = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q  <= ST_IDLE;
            period_q <= '0;
            rep_q    <= '0;
            busy     <= 1'b0;
            rollover <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                period_q <= bus.period;
                rep_q    <= bus.reps;
            end else if (rep_dec) begin
                rep_q <= rep_q - 1'b1;
            end
            busy     <= (state_d == ST_RUN);
            rollover <= roll_d;
            done     <= (state_d == ST_DONE);
            err      <= err_d;
        end
    end

    assign bus.Q        = count;
    assign bus.busy     = busy;
    assign bus.rollover = rollover;
    assign bus.done     = done;
    assign bus.err      = err;

endmodule
